// File: rtl/fj_pkg.sv
// Shared types and width helpers for the fork/join dispatcher.
package fj_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        FJ_JOIN      = 2'd0,
        FJ_JOIN_ANY  = 2'd1,
        FJ_JOIN_NONE = 2'd2
    } fj_mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        JOIN_WAIT = 2'd1,
        BG        = 2'd2
    } fj_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fj_watchdog.sv
// Saturating cycle counter: clear wins over enable, expire flags LIMIT reached while enabled.
module fj_watchdog
    import fj_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = cnt_width(LIMIT);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIM);

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join dispatcher: launches worker lanes and releases the parent with join/join_any/join_none.
// Optional JOIN_WAIT watchdog is compiled in with FJ_TIMEOUT_EN.
module fork_join_ctrl
    import fj_pkg::*;
#(
    parameter int unsigned N_LANES        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fork_valid_i,
    output logic               fork_ready_o,
    input  logic [N_LANES-1:0] fork_mask_i,
    input  logic [MODE_W-1:0]  fork_mode_i,
    output logic [N_LANES-1:0] start_o,
    input  logic [N_LANES-1:0] lane_done_i,
    output logic [N_LANES-1:0] kill_o,
    output logic               join_done_o,
    output logic               join_killed_o,
    output logic               join_timeout_o,
    input  logic               wait_fork_req_i,
    output logic               wait_done_o,
    input  logic               disable_req_i,
    output logic [N_LANES-1:0] outstanding_o,
    output logic               spurious_err_o
);

    fj_state_e          state_q, state_d;
    fj_mode_e           mode_q, mode_d;
    logic [N_LANES-1:0] out_q, out_d, cur_q, cur_d;
    logic [N_LANES-1:0] start_q, start_d, kill_q, kill_d;
    logic               jd_q, jd_d, jk_q, jk_d, jt_q, jt_d;
    logic               wd_q, wd_d, pend_q, pend_d, spur_q, spur_d;
    logic [N_LANES-1:0] live, done_v;
    logic               accept, released, wd_expire;

    assign fork_ready_o = !rst_i && (state_q != JOIN_WAIT) && !disable_req_i
                          && ((fork_mask_i & out_q) == '0);
    assign accept = fork_valid_i && fork_ready_o;

    // Lanes launched this cycle only start being watched from the following cycle.
    assign live   = out_q & ~start_q;
    assign done_v = lane_done_i & live;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        out_d    = out_q;
        cur_d    = cur_q;
        start_d  = '0;
        kill_d   = '0;
        jd_d     = 1'b0;
        jk_d     = 1'b0;
        jt_d     = 1'b0;
        wd_d     = 1'b0;
        pend_d   = pend_q | wait_fork_req_i;
        spur_d   = spur_q;
        released = 1'b0;

        if (disable_req_i) begin
            kill_d  = out_q;
            out_d   = '0;
            state_d = IDLE;
            if (state_q == JOIN_WAIT) begin
                jd_d = 1'b1;
                jk_d = 1'b1;
            end
        end else begin
            if ((lane_done_i & ~live) != '0) begin
                spur_d = 1'b1;
            end
            out_d = (out_q & ~done_v) | (accept ? fork_mask_i : '0);
            if (state_q == JOIN_WAIT) begin
                if (mode_q == FJ_JOIN_ANY) begin
                    released = (cur_q & done_v) != '0;
                end else begin
                    released = (cur_q & out_q & ~done_v) == '0;
                end
                if (released) begin
                    jd_d    = 1'b1;
                    state_d = (out_d != '0) ? BG : IDLE;
                end else if (wd_expire) begin
                    jd_d    = 1'b1;
                    jt_d    = 1'b1;
                    state_d = BG;
                end
            end else begin
                state_d = (out_d != '0) ? BG : IDLE;
                if (accept) begin
                    start_d = fork_mask_i;
                    cur_d   = fork_mask_i;
                    mode_d  = (fork_mode_i == FJ_JOIN_ANY) ? FJ_JOIN_ANY : FJ_JOIN;
                    if ((fork_mode_i == FJ_JOIN_NONE) || (fork_mask_i == '0)) begin
                        jd_d = 1'b1;
                    end else begin
                        state_d = JOIN_WAIT;
                    end
                end
            end
        end

        if (pend_d && (out_d == '0)) begin
            wd_d   = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= FJ_JOIN;
            out_q   <= '0;
            cur_q   <= '0;
            start_q <= '0;
            kill_q  <= '0;
            jd_q    <= 1'b0;
            jk_q    <= 1'b0;
            jt_q    <= 1'b0;
            wd_q    <= 1'b0;
            pend_q  <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            kill_q  <= kill_d;
            jd_q    <= jd_d;
            jk_q    <= jk_d;
            jt_q    <= jt_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
            spur_q  <= spur_d;
        end
    end

`ifdef FJ_TIMEOUT_EN
    fj_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (state_q != JOIN_WAIT),
        .en_i    (state_q == JOIN_WAIT),
        .expire_o(wd_expire)
    );
    assign join_timeout_o = jt_q;
`else
    logic unused_timeout;
    assign unused_timeout = jt_q ^ (TIMEOUT_CYCLES != 0);
    assign wd_expire      = 1'b0;
    assign join_timeout_o = 1'b0;
`endif

    assign start_o        = start_q;
    assign kill_o         = kill_q;
    assign join_done_o    = jd_q;
    assign join_killed_o  = jk_q;
    assign wait_done_o    = wd_q;
    assign outstanding_o  = out_q;
    assign spurious_err_o = spur_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed scenarios plus randomized traffic against a per-lane behavioural model.
module tb_fork_join_ctrl;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef FJ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         fork_valid_i = 1'b0;
    logic [N-1:0] fork_mask_i = '0;
    logic [1:0]   fork_mode_i = '0;
    logic [N-1:0] lane_done_i = '0;
    logic         wait_fork_req_i = 1'b0;
    logic         disable_req_i = 1'b0;
    logic         fork_ready_o, join_done_o, join_killed_o, join_timeout_o;
    logic         wait_done_o, spurious_err_o;
    logic [N-1:0] start_o, kill_o, outstanding_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fork_join_ctrl #(.N_LANES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .fork_valid_i(fork_valid_i), .fork_ready_o(fork_ready_o),
        .fork_mask_i(fork_mask_i), .fork_mode_i(fork_mode_i),
        .start_o(start_o), .lane_done_i(lane_done_i), .kill_o(kill_o),
        .join_done_o(join_done_o), .join_killed_o(join_killed_o),
        .join_timeout_o(join_timeout_o), .wait_fork_req_i(wait_fork_req_i),
        .wait_done_o(wait_done_o), .disable_req_i(disable_req_i),
        .outstanding_o(outstanding_o), .spurious_err_o(spurious_err_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; pulse inputs drop back to idle afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fork_valid_i    = 1'b0;
        lane_done_i     = '0;
        wait_fork_req_i = 1'b0;
        disable_req_i   = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic issue_fork(input logic [N-1:0] mask, input logic [1:0] mode);
        fork_valid_i = 1'b1;
        fork_mask_i  = mask;
        fork_mode_i  = mode;
    endtask

    // ---------------- behavioural model: per-lane status 0 free, 1 launched, 2 running
    int           m_lane [N];
    bit           m_blocked, m_any, m_pend, m_spur;
    bit [N-1:0]   m_grp;
    int           m_wcnt;
    bit [N-1:0]   e_start, e_kill, e_out;
    bit           e_jd, e_jk, e_jt, e_wd;

    function automatic bit [N-1:0] model_busy();
        bit [N-1:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = (m_lane[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_lane[i] = 0;
        m_blocked = 0; m_any = 0; m_pend = 0; m_spur = 0; m_grp = '0; m_wcnt = 0;
    endtask

    task automatic model_step(input bit fv, input bit [N-1:0] mask, input bit [1:0] mode,
                              input bit [N-1:0] done, input bit wfr, input bit dis,
                              output bit rdy);
        bit [N-1:0] busy, finished;
        bit accept, rel;
        busy   = model_busy();
        rdy    = !m_blocked && !dis && ((mask & busy) == 0);
        accept = fv && rdy;
        e_start = '0; e_kill = '0; e_jd = 0; e_jk = 0; e_jt = 0; e_wd = 0;
        finished = '0;
        if (dis) begin
            e_kill = busy;
            for (int i = 0; i < N; i++) m_lane[i] = 0;
            if (m_blocked) begin e_jd = 1; e_jk = 1; end
            m_blocked = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (done[i] && m_lane[i] == 2) begin
                    m_lane[i] = 0;
                    finished[i] = 1;
                end else begin
                    if (done[i]) m_spur = 1;
                    if (m_lane[i] == 1) m_lane[i] = 2;
                end
            end
            if (m_blocked) begin
                rel = m_any ? ((finished & m_grp) != 0) : ((model_busy() & m_grp) == 0);
                if (rel) begin
                    e_jd = 1; m_blocked = 0;
                end else if (TMO_EN && m_wcnt == TO) begin
                    e_jd = 1; e_jt = 1; m_blocked = 0;
                end else begin
                    m_wcnt++;
                end
            end else if (accept) begin
                for (int i = 0; i < N; i++) if (mask[i]) m_lane[i] = 1;
                e_start = mask;
                if (mode == 2 || mask == 0) begin
                    e_jd = 1;
                end else begin
                    m_blocked = 1; m_grp = mask; m_any = (mode == 1); m_wcnt = 0;
                end
            end
        end
        m_pend = m_pend || wfr;
        if (m_pend && model_busy() == 0) begin e_wd = 1; m_pend = 0; end
        e_out = model_busy();
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        do_reset();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({fork_ready_o, start_o, kill_o, join_done_o, join_killed_o, join_timeout_o,
             wait_done_o, outstanding_o, spurious_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b start=%b kill=%b jd=%b out=%b spur=%b required all 0",
                     fork_ready_o, start_o, kill_o, join_done_o, outstanding_o, spurious_err_o);
        end
        rst_i = 1'b0;
        cyc = 0;
        step();
        issue_fork(4'b1111, 2'd0);
        step();
        step();
        rst_i = 1'b1;
        step();
        checks++;
        if (kill_o !== 4'b0000 || outstanding_o !== 4'b0000 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: kill=%b out=%b jd=%b required 0000 0000 0",
                     kill_o, outstanding_o, join_done_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_join();
        do_reset();
        step();
        issue_fork(4'b0011, 2'd0);
        step();
        checks++;
        if (start_o !== 4'b0011 || outstanding_o !== 4'b0011 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL join_start: start=%b out=%b jd=%b required 0011 0011 0",
                     start_o, outstanding_o, join_done_o);
        end
        run_to(6);
        lane_done_i = 4'b0001;
        step();
        checks++;
        if (outstanding_o !== 4'b0010 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL join_partial: out=%b jd=%b required 0010 0", outstanding_o, join_done_o);
        end
        run_to(9);
        lane_done_i = 4'b0010;
        step();
        fork_mask_i = 4'b1111;
        #1;
        checks++;
        if (join_done_o !== 1'b1 || outstanding_o !== 4'b0000 || fork_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL join_release: jd=%b out=%b rdy=%b required 1 0000 1",
                     join_done_o, outstanding_o, fork_ready_o);
        end
    endtask

    task automatic test_join_any();
        do_reset();
        step();
        issue_fork(4'b0111, 2'd1);
        run_to(4);
        lane_done_i = 4'b0100;
        step();
        checks++;
        if (join_done_o !== 1'b1 || outstanding_o !== 4'b0011) begin
            errors++;
            $display("FAIL join_any_release: jd=%b out=%b required 1 0011", join_done_o, outstanding_o);
        end
        step();
        wait_fork_req_i = 1'b1;
        run_to(12);
        checks++;
        if (wait_done_o !== 1'b0 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_early: wd=%b jd=%b required 0 0", wait_done_o, join_done_o);
        end
        lane_done_i = 4'b0011;
        step();
        checks++;
        if (wait_done_o !== 1'b1 || outstanding_o !== 4'b0000) begin
            errors++;
            $display("FAIL wait_done: wd=%b out=%b required 1 0000", wait_done_o, outstanding_o);
        end
        step();
        checks++;
        if (wait_done_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_single_pulse: wd=%b required 0", wait_done_o);
        end
    endtask

    task automatic test_join_none();
        do_reset();
        step();
        issue_fork(4'b0011, 2'd2);
        step();
        checks++;
        if (join_done_o !== 1'b1 || start_o !== 4'b0011) begin
            errors++;
            $display("FAIL join_none_release: jd=%b start=%b required 1 0011", join_done_o, start_o);
        end
        step();
        issue_fork(4'b0001, 2'd0);
        #1;
        checks++;
        if (fork_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL overlap_ready: rdy=%b required 0", fork_ready_o);
        end
        fork_mask_i = 4'b1100;
        #1;
        checks++;
        if (fork_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bg_disjoint_ready: rdy=%b required 1", fork_ready_o);
        end
        step();
        checks++;
        if (start_o !== 4'b1100 || outstanding_o !== 4'b1111) begin
            errors++;
            $display("FAIL bg_second_fork: start=%b out=%b required 1100 1111", start_o, outstanding_o);
        end
    endtask

    task automatic test_disable();
        do_reset();
        step();
        issue_fork(4'b1111, 2'd0);
        run_to(5);
        disable_req_i = 1'b1;
        lane_done_i   = 4'b0001;
        #1;
        checks++;
        if (fork_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_ready: rdy=%b required 0", fork_ready_o);
        end
        step();
        checks++;
        if (kill_o !== 4'b1111 || join_done_o !== 1'b1 || join_killed_o !== 1'b1 ||
            outstanding_o !== 4'b0000 || spurious_err_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_kill: kill=%b jd=%b jk=%b out=%b spur=%b required 1111 1 1 0000 0",
                     kill_o, join_done_o, join_killed_o, outstanding_o, spurious_err_o);
        end
        step();
        checks++;
        if (kill_o !== 4'b0000 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_pulse: kill=%b jd=%b required 0000 0", kill_o, join_done_o);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        step();
        lane_done_i = 4'b1000;
        step();
        checks++;
        if (spurious_err_o !== 1'b1) begin
            errors++;
            $display("FAIL spurious_set: spur=%b required 1", spurious_err_o);
        end
        run_to(10);
        checks++;
        if (spurious_err_o !== 1'b1) begin
            errors++;
            $display("FAIL spurious_sticky: spur=%b required 1", spurious_err_o);
        end
        do_reset();
        checks++;
        if (spurious_err_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_clear: spur=%b required 0", spurious_err_o);
        end
    endtask

`ifdef FJ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        step();
        issue_fork(4'b0001, 2'd0);
        run_to(10);
        checks++;
        if (join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: jd=%b required 0", join_done_o);
        end
        step();
        checks++;
        if (join_done_o !== 1'b1 || join_timeout_o !== 1'b1 || outstanding_o !== 4'b0001 ||
            kill_o !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_release: jd=%b jt=%b out=%b kill=%b required 1 1 0001 0000",
                     join_done_o, join_timeout_o, outstanding_o, kill_o);
        end
        rst_i = 1'b1;
        step();
        checks++;
        if (kill_o !== 4'b0000 || outstanding_o !== 4'b0000 || join_done_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset: kill=%b out=%b jd=%b required 0000 0000 0",
                     kill_o, outstanding_o, join_done_o);
        end
        rst_i = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit           exp_rdy, fv, wfr, dis;
        bit [N-1:0]   mask, done;
        bit [1:0]     mode;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            fv   = ($urandom_range(2) == 0);
            mask = N'($urandom_range(15));
            mode = 2'($urandom_range(3));
            done = '0;
            for (int i = 0; i < N; i++)
                if (m_lane[i] == 2 && $urandom_range(3) == 0) done[i] = 1'b1;
            wfr  = ($urandom_range(9) == 0);
            dis  = ($urandom_range(39) == 0);
            fork_valid_i = fv; fork_mask_i = mask; fork_mode_i = mode;
            lane_done_i = done; wait_fork_req_i = wfr; disable_req_i = dis;
            #1;
            model_step(fv, mask, mode, done, wfr, dis, exp_rdy);
            checks++;
            if (fork_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready c=%0d: got %b required %b", c, fork_ready_o, exp_rdy);
            end
            step();
            checks++;
            if (start_o !== e_start || kill_o !== e_kill || outstanding_o !== e_out) begin
                errors++;
                $display("FAIL rnd_lanes c=%0d: start=%b kill=%b out=%b required %b %b %b",
                         c, start_o, kill_o, outstanding_o, e_start, e_kill, e_out);
            end
            checks++;
            if (join_done_o !== e_jd || join_killed_o !== e_jk || join_timeout_o !== e_jt ||
                wait_done_o !== e_wd || spurious_err_o !== m_spur) begin
                errors++;
                $display("FAIL rnd_flags c=%0d: jd=%b jk=%b jt=%b wd=%b spur=%b required %b %b %b %b %b",
                         c, join_done_o, join_killed_o, join_timeout_o, wait_done_o, spurious_err_o,
                         e_jd, e_jk, e_jt, e_wd, m_spur);
            end
        end
    endtask

    initial begin
        test_reset();
        test_join();
        test_join_any();
        test_join_none();
        test_disable();
        test_spurious();
`ifdef FJ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Hardware dispatcher that launches up to N_LANES parallel worker lanes with one fork request.
- Tracks each lane's completion and releases the parent with join, join_any or join_none semantics.
- Also provides wait-fork (wait for all outstanding lanes) and disable-fork (kill all outstanding lanes).
- Sits between a sequencing master, which issues fork requests, and the worker lanes, which consume start/kill and return lane_done.

Parameters:
- N_LANES, 4, number of worker lanes (2..16).
- TIMEOUT_CYCLES, 64, watchdog limit in JOIN_WAIT; used only with FJ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fork_valid  in  1  fork request valid.
- fork_ready  out  1  fork request can be accepted this cycle.
- fork_mask  in  N_LANES  lanes to launch.
- fork_mode  in  2  0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE; 3 is reserved and treated as JOIN.
- start  out  N_LANES  one-cycle launch pulse per lane.
- lane_done  in  N_LANES  one-cycle completion pulse per lane.
- kill  out  N_LANES  one-cycle abort pulse per lane.
- join_done  out  1  one-cycle parent-release pulse.
- join_killed  out  1  qualifies join_done: release caused by disable.
- join_timeout  out  1  qualifies join_done: release caused by watchdog.
- wait_fork_req  in  1  pulse: request notification when all outstanding lanes have finished.
- wait_done  out  1  one-cycle pulse answering wait_fork_req.
- disable_req  in  1  pulse: kill every outstanding lane.
- outstanding  out  N_LANES  lanes launched and not yet done or killed.
- spurious_err  out  1  sticky: lane_done seen on a non-outstanding lane.

Behaviour:
- Reset: all outputs 0; state IDLE; internal pending flags and watchdog counter cleared. Reset mid-operation drops all lanes silently; no kill pulses are issued.
- States:
  - IDLE: outstanding==0.
  - JOIN_WAIT: parent blocked.
  - BG: parent released, outstanding!=0.
- fork_ready = (state!=JOIN_WAIT) && !disable_req && ((fork_mask & outstanding)==0).
- Acceptance in cycle T (fork_valid && fork_ready):
  - cycle T+1: start[i]=1 for every set mask bit; outstanding |= fork_mask.
  - The fork's own lane set is latched as cur_mask.
- lane_done is sampled from the cycle after start (T+2 onward).
  - A done on an outstanding lane clears outstanding[i] in the next cycle.
  - A done on any other lane is ignored and sets spurious_err.
- Release rules:
  - JOIN_NONE: join_done at T+1. Next state is BG, or IDLE if the mask is empty.
  - JOIN_ANY: go to JOIN_WAIT; join_done the cycle after the first done within cur_mask; then BG or IDLE.
  - JOIN: go to JOIN_WAIT; join_done the cycle after the last cur_mask lane completes.
  - Empty mask: join_done at T+1 in every mode, and state stays IDLE.
  - Simultaneous dones in JOIN_ANY produce exactly one join_done.
- A new fork is allowed in BG on disjoint lanes. Older background lanes do not affect the new fork's join condition.
- wait_fork_req:
  - Sets wait_pend.
  - wait_done pulses the cycle after outstanding becomes 0, then wait_pend clears.
  - If outstanding is already 0, wait_done pulses in the next cycle.
  - Repeated requests while pending are merged into one pulse.
- disable_req in cycle D:
  - D+1: kill=outstanding; outstanding cleared; state IDLE.
  - If in JOIN_WAIT, join_done=1 with join_killed=1.
  - If wait_pend is set, wait_done=1.
  - lane_done in cycle D is ignored and is not flagged as spurious.
- Priority: rst > disable_req > lane_done > fork acceptance.

Optional Feature:
- Macro: FJ_TIMEOUT_EN.
- Defined:
  - A counter runs in JOIN_WAIT, cleared on entry.
  - When it reaches TIMEOUT_CYCLES, the next cycle gives join_done=1 with join_timeout=1 and state moves to BG.
  - Lanes are not killed by the timeout.
- Undefined: no counter; join_timeout is tied to 0; the TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Package fj_pkg holds:
  - typedef enum fj_mode_e {FJ_JOIN, FJ_JOIN_ANY, FJ_JOIN_NONE}.
  - typedef enum fj_state_e {IDLE, JOIN_WAIT, BG}.
  - Localparam width helpers.
- One sub-module, fj_watchdog: a counter with clear, enable and expire signals. It is instantiated only under FJ_TIMEOUT_EN.

Test Plan:
1. JOIN, mask 0011, accepted in cycle 1:
   - start=0011 at cycle 2.
   - Lane0 done at 6, lane1 done at 9 → join_done at 10; outstanding=0000 and state IDLE at 10.
2. JOIN_ANY, mask 0111:
   - lane2 done at 4 → join_done at 5; outstanding=0011.
   - wait_fork_req at 6; lanes 0 and 1 done at 12 → wait_done at 13.
3. JOIN_NONE, mask 0011, accepted in cycle 1:
   - join_done and start at 2.
   - Second fork, mask 1100 JOIN, at cycle 3 is accepted.
   - A fork with mask 0001 at cycle 3 gives fork_ready=0.
4. JOIN, mask 1111; disable_req at 5 with lane_done[0] also at 5:
   - kill=1111, join_done=1, join_killed=1 at 6.
   - spurious_err stays 0.
5. lane_done[3] pulsed with outstanding=0000 → spurious_err=1 and stays set until rst.
6. With FJ_TIMEOUT_EN and TIMEOUT_CYCLES=8, JOIN on mask 0001 with no done:
   - join_done with join_timeout=1 exactly 9 cycles after entering JOIN_WAIT.
   - outstanding still 0001.
   - rst then clears everything with no kill pulse.
